// File: rtl/prog_clk_divider_pkg.sv
// Shared constants and the parameter-legality helper for the programmable clock divider.
package prog_clk_divider_pkg;

    localparam int DEF_W        = 8;
    localparam int DEF_RST_DIV  = 24;
    localparam int DEF_RST_HIGH = 12;
    localparam int MIN_DIV      = 2;
    localparam int MIN_HIGH     = 1;

    // True when the reset divisor fits the counter and leaves at least one low cycle.
    function automatic bit params_ok(input int w, input int div, input int high);
        longint div_limit;
        div_limit = longint'(1) << w;
        return (div >= MIN_DIV) && (longint'(div) < div_limit) &&
               (high >= MIN_HIGH) && (high < div);
    endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Control/status bundle of the divider: the master drives control and config, the slave reports.
interface prog_clk_divider_if
    import prog_clk_divider_pkg::*;
#(
    parameter int W = DEF_W
);
    logic         en;
    logic         clr;
    logic         cfg_load;
    logic [W-1:0] div_val;
    logic [W-1:0] high_val;
    logic [W-1:0] count;
    logic         clk_out;
    logic         tc;
    logic         cfg_pending;

    modport master (
        output en, clr, cfg_load, div_val, high_val,
        input  count, clk_out, tc, cfg_pending
    );

    modport slave (
        input  en, clr, cfg_load, div_val, high_val,
        output count, clk_out, tc, cfg_pending
    );
endinterface

// File: rtl/prog_clk_divider_cfg.sv
// Clamps requested divisor/high-phase values and holds them pending until the counter
// restarts its period, so the active configuration only ever changes at count 0.
module prog_clk_divider_cfg
    import prog_clk_divider_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int RST_DIV  = DEF_RST_DIV,
    parameter int RST_HIGH = DEF_RST_HIGH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_load,
    input  logic [W-1:0] div_val,
    input  logic [W-1:0] high_val,
    input  logic         apply,
    output logic [W-1:0] n_act,
    output logic [W-1:0] h_next,
    output logic         cfg_pending
);

    localparam logic [W-1:0] MIN_DIV_W  = W'(MIN_DIV);
    localparam logic [W-1:0] MIN_HIGH_W = W'(MIN_HIGH);
    localparam logic [W-1:0] RST_DIV_W  = W'(RST_DIV);
    localparam logic [W-1:0] RST_HIGH_W = W'(RST_HIGH);

    logic [W-1:0] n_act_reg;
    logic [W-1:0] h_act_reg;
    logic [W-1:0] n_pend_reg;
    logic [W-1:0] h_pend_reg;
    logic         pend_reg;

    logic [W-1:0] n_clamp;
    logic [W-1:0] n_clamp_m1;
    logic [W-1:0] h_floor;
    logic [W-1:0] h_clamp;
    logic         apply_pend;

    // High phase is limited against the already-clamped divisor so at least one low cycle remains.
    always_comb begin
        n_clamp    = (div_val < MIN_DIV_W) ? MIN_DIV_W : div_val;
        n_clamp_m1 = n_clamp - 1'b1;
        h_floor    = (high_val < MIN_HIGH_W) ? MIN_HIGH_W : high_val;
        h_clamp    = (h_floor > n_clamp_m1) ? n_clamp_m1 : h_floor;
    end

    assign apply_pend = apply && pend_reg;

    // A load on the apply edge lands after the transfer: old pending goes active, new stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_act_reg  <= RST_DIV_W;
            h_act_reg  <= RST_HIGH_W;
            n_pend_reg <= RST_DIV_W;
            h_pend_reg <= RST_HIGH_W;
            pend_reg   <= 1'b0;
        end else begin
            if (apply_pend) begin
                n_act_reg <= n_pend_reg;
                h_act_reg <= h_pend_reg;
                pend_reg  <= 1'b0;
            end
            if (cfg_load) begin
                n_pend_reg <= n_clamp;
                h_pend_reg <= h_clamp;
                pend_reg   <= 1'b1;
            end
        end
    end

    assign n_act       = n_act_reg;
    assign h_next      = apply_pend ? h_pend_reg : h_act_reg;
    assign cfg_pending = pend_reg;

endmodule

// File: rtl/prog_clk_divider.sv
// Programmable clock divider: period counter with a registered divided clock that is high
// while count < H and a terminal-count flag; config changes take effect at the period start.
module prog_clk_divider
    import prog_clk_divider_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int RST_DIV  = DEF_RST_DIV,
    parameter int RST_HIGH = DEF_RST_HIGH
) (
    input  logic               clk,
    input  logic               rst,
    prog_clk_divider_if.slave  bus
);

    if (!params_ok(W, RST_DIV, RST_HIGH)) begin : g_bad_params
        $error("prog_clk_divider: need 2 <= RST_DIV < 2**W and 1 <= RST_HIGH < RST_DIV");
    end

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;
    logic         clk_out_reg;
    logic         clk_out_next;
    logic [W-1:0] n_act;
    logic [W-1:0] n_act_m1;
    logic [W-1:0] h_next;
    logic         cfg_pending;
    logic         wrap;
    logic         apply;

    prog_clk_divider_cfg #(
        .W        (W),
        .RST_DIV  (RST_DIV),
        .RST_HIGH (RST_HIGH)
    ) u_cfg (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (bus.cfg_load),
        .div_val     (bus.div_val),
        .high_val    (bus.high_val),
        .apply       (apply),
        .n_act       (n_act),
        .h_next      (h_next),
        .cfg_pending (cfg_pending)
    );

    assign n_act_m1 = n_act - 1'b1;
    assign wrap     = bus.en && (count_reg == n_act_m1);
    assign apply    = bus.clr || wrap;

    // clk_out is derived from the post-update count and config so it is high exactly when count < H.
    always_comb begin
        count_next   = count_reg;
        clk_out_next = clk_out_reg;
        if (bus.clr) begin
            count_next = '0;
        end else if (bus.en) begin
            count_next = wrap ? '0 : count_reg + 1'b1;
        end
        if (bus.clr || bus.en) begin
            clk_out_next = (count_next < h_next);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg   <= '0;
            clk_out_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            clk_out_reg <= clk_out_next;
        end
    end

    assign bus.count       = count_reg;
    assign bus.clk_out     = clk_out_reg;
    assign bus.tc          = wrap;
    assign bus.cfg_pending = cfg_pending;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed self-checking bench for prog_clk_divider with default parameters (N=24, H=12).
module tb_prog_clk_divider;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    prog_clk_divider_if #(.W(W)) bus ();

    prog_clk_divider #(
        .W        (W),
        .RST_DIV  (24),
        .RST_HIGH (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input int cnt, input int co, input int t);
        check({tag, " count"},   32'(bus.count),   32'(cnt));
        check({tag, " clk_out"}, 32'(bus.clk_out), 32'(co));
        check({tag, " tc"},      32'(bus.tc),      32'(t));
    endtask

    task automatic set_load(input int div, input int high);
        bus.cfg_load = 1'b1;
        bus.div_val  = W'(div);
        bus.high_val = W'(high);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.clr      = 1'b0;
        bus.cfg_load = 1'b0;
        bus.div_val  = '0;
        bus.high_val = '0;

        // Reset state and hold-off of clk_out until the first enabled edge
        #1;
        expect_state("reset", 0, 0, 0);
        check("reset pending", 32'(bus.cfg_pending), 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        expect_state("idle after reset", 0, 0, 0);
        $display("reset: count=%0d clk_out=%0d", bus.count, bus.clk_out);

        // Free run with defaults: 24-cycle period, 12 high
        bus.en = 1'b1;
        #1;
        check("t1 start tc", 32'(bus.tc), 0);
        for (int k = 1; k <= 48; k++) begin
            tick();
            expect_state($sformatf("t1 k%0d", k), k % 24, int'((k % 24) < 12), int'((k % 24) == 23));
        end
        $display("t1: two default periods run, count=%0d", bus.count);

        // Load N=5,H=2 at count 10; applies only at the 23->0 wrap
        repeat (10) tick();
        check("t2 count at load", 32'(bus.count), 10);
        set_load(5, 2);
        tick();
        bus.cfg_load = 1'b0;
        check("t2 pending set", 32'(bus.cfg_pending), 1);
        check("t2 count 11", 32'(bus.count), 11);
        repeat (12) tick();
        expect_state("t2 pre-wrap", 23, 0, 1);
        check("t2 pending pre-wrap", 32'(bus.cfg_pending), 1);
        tick();
        expect_state("t2 wrap", 0, 1, 0);
        check("t2 pending cleared", 32'(bus.cfg_pending), 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            expect_state($sformatf("t2 k%0d", k), k % 5, int'((k % 5) < 2), int'((k % 5) == 4));
        end
        $display("t2: N=5 H=2 applied at wrap, count=%0d", bus.count);

        // Clamping: 0/0 -> N=2,H=1 ; 7/7 -> N=7,H=6
        set_load(0, 0);
        tick();
        bus.cfg_load = 1'b0;
        expect_state("t3 after load", 1, 1, 0);
        check("t3 pending", 32'(bus.cfg_pending), 1);
        repeat (4) tick();
        expect_state("t3 wrap N2", 0, 1, 0);
        check("t3 pending cleared", 32'(bus.cfg_pending), 0);
        tick();
        expect_state("t3 toggle low", 1, 0, 1);
        tick();
        expect_state("t3 toggle high", 0, 1, 0);
        set_load(7, 7);
        tick();
        bus.cfg_load = 1'b0;
        expect_state("t3 N2 tail", 1, 0, 1);
        check("t3 pending 7", 32'(bus.cfg_pending), 1);
        tick();
        expect_state("t3 wrap N7", 0, 1, 0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            expect_state($sformatf("t3 k%0d", k), k % 7, int'((k % 7) < 6), int'((k % 7) == 6));
        end
        $display("t3: clamped configs 2/1 and 7/6 observed, count=%0d", bus.count);

        // Restore defaults, then freeze with en low at count 8 while loading 6/3
        set_load(24, 12);
        tick();
        bus.cfg_load = 1'b0;
        expect_state("t4 after load", 1, 1, 0);
        repeat (6) tick();
        expect_state("t4 wrap N24", 0, 1, 0);
        repeat (8) tick();
        expect_state("t4 at 8", 8, 1, 0);
        bus.en = 1'b0;
        set_load(6, 3);
        #1;
        check("t4 tc en low", 32'(bus.tc), 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            bus.cfg_load = 1'b0;
            expect_state($sformatf("t4 hold k%0d", k), 8, 1, 0);
        end
        check("t4 load while disabled", 32'(bus.cfg_pending), 1);
        bus.en = 1'b1;
        tick();
        expect_state("t4 resume", 9, 1, 0);
        repeat (6) tick();
        expect_state("t4 at 15", 15, 0, 0);
        $display("t4: hold with en low, resumed count=%0d", bus.count);

        // clr + cfg_load together: old pending (6/3) applied, new (4/1) stays pending
        bus.clr = 1'b1;
        set_load(4, 1);
        tick();
        bus.clr      = 1'b0;
        bus.cfg_load = 1'b0;
        expect_state("t5 clr", 0, 1, 0);
        check("t5 new pending", 32'(bus.cfg_pending), 1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            expect_state($sformatf("t5 N6 k%0d", k), k % 6, int'((k % 6) < 3), int'((k % 6) == 5));
        end
        check("t5 pending applied", 32'(bus.cfg_pending), 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect_state($sformatf("t5 N4 k%0d", k), k % 4, int'((k % 4) < 1), int'((k % 4) == 3));
        end
        tick();
        expect_state("t5 before clr", 1, 0, 0);
        bus.en  = 1'b0;
        bus.clr = 1'b1;
        #1;
        check("t5 tc clr en low", 32'(bus.tc), 0);
        tick();
        bus.clr = 1'b0;
        expect_state("t5 clr en low", 0, 1, 0);
        bus.en = 1'b1;
        $display("t5: clr with concurrent load, count=%0d", bus.count);

        // Asynchronous reset mid-period with pending config
        set_load(24, 12);
        tick();
        bus.cfg_load = 1'b0;
        expect_state("t6 load", 1, 0, 0);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        expect_state("t6 clr N24", 0, 1, 0);
        repeat (16) tick();
        set_load(5, 2);
        tick();
        bus.cfg_load = 1'b0;
        expect_state("t6 at 17", 17, 0, 0);
        check("t6 pending before rst", 32'(bus.cfg_pending), 1);
        #2;
        rst = 1'b1;
        #1;
        expect_state("t6 async rst", 0, 0, 0);
        check("t6 rst pending", 32'(bus.cfg_pending), 0);
        rst = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            expect_state($sformatf("t6 k%0d", k), k % 24, int'((k % 24) < 12), int'((k % 24) == 23));
        end
        check("t6 pending after period", 32'(bus.cfg_pending), 0);
        $display("t6: reset discarded pending, period back to 24, count=%0d", bus.count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 Parameter W, default 8: width of counter and configuration fields.
REQ-002 Parameter RST_DIV, default 24: divisor N loaded at reset.
REQ-003 Parameter RST_HIGH, default 12: high-phase length H loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  count enable; low holds all state.
REQ-007 clr  input  1  synchronous restart of the period.
REQ-008 cfg_load  input  1  one-cycle strobe capturing div_val/high_val into pending config.
REQ-009 div_val  input  W  requested divisor N.
REQ-010 high_val  input  W  requested high-phase cycles H.
REQ-011 count  output  W  current position in period, 0..N_act-1.
REQ-012 clk_out  output  1  registered divided clock.
REQ-013 tc  output  1  terminal-count flag.
REQ-014 cfg_pending  output  1  pending config not yet applied.

Function
REQ-015 Active config (N_act, H_act) and pending config (N_pend, H_pend) SHALL be separate registers.
REQ-016 cfg_load SHALL clamp values, then write pending and set cfg_pending: N = max(div_val, 2); H = min(max(high_val, 1), N-1) using the clamped N.
REQ-017 A cfg_load while cfg_pending is set SHALL overwrite pending; last load wins.
REQ-018 Enabled edge with count == N_act-1 (wrap) SHALL set count to 0 and, if cfg_pending, copy pending to active and clear cfg_pending in the same edge.
REQ-019 Enabled edge without wrap SHALL increment count by 1; no other wrap point exists.
REQ-020 clk_out SHALL be updated on every enabled or clr edge to (count_next < H_next), using post-update count and active config, so clk_out is 1 exactly when count < H_act.
REQ-021 tc SHALL be combinational: en && count == N_act-1.
REQ-022 en low SHALL hold count, clk_out and active config; cfg_load SHALL still be accepted.
REQ-023 clr high SHALL set count to 0 and clk_out to 1, and apply pending config if cfg_pending, regardless of en.
REQ-024 Priority SHALL be rst > clr > en; cfg_load SHALL combine with any of them.
REQ-025 If cfg_load coincides with a wrap or clr edge, the old pending value SHALL be applied and the new one SHALL remain pending.
REQ-026 If N_act shrinks, no count value SHALL exceed N_act-1, because config changes only at count 0.

Reset
REQ-027 rst SHALL immediately set count=0, clk_out=0, cfg_pending=0, N_act=N_pend=RST_DIV, H_act=H_pend=RST_HIGH.
REQ-028 After reset release, clk_out SHALL remain 0 until the first enabled or clr edge; from then on REQ-020 SHALL hold.
REQ-029 Assertion of rst mid-period SHALL discard pending config.

Structure
REQ-030 Package prog_clk_divider_pkg SHALL hold the RST_DIV and RST_HIGH defaults and the minimum-divisor constant 2.
REQ-031 Clamping and the pending/active registers SHALL sit in sub-module prog_clk_divider_cfg; counter and clk_out sit in the top.
REQ-032 Parameter legality SHALL be checked at elaboration: 2 <= RST_DIV < 2^W, and 1 <= RST_HIGH < RST_DIV.

Verification
REQ-033 Reset, en=1, defaults -> count 0..23 repeating; clk_out high 12 and low 12 cycles; tc once per 24 cycles.
REQ-034 cfg_load N=5, H=2 at count=10 -> period stays 24 until wrap; cfg_pending=1 until the 23->0 edge; then count 0..4 with clk_out 1,1,0,0,0.
REQ-035 cfg_load div_val=0, high_val=0, then div_val=7, high_val=7 -> N=2, H=1 (toggle), then N=7, H=6.
REQ-036 en low for 5 cycles at count=8 -> count, clk_out frozen and tc=0; resumes at 9.
REQ-037 clr at count=15 with cfg_load in the same cycle -> count=0, clk_out=1 next; old pending applied, new one pending.
REQ-038 rst asserted mid-edge at count=17 with pending config -> outputs zero immediately; N_act back to 24, cfg_pending=0.
